led_chaser: RTL

Parametrised running-light driver for the board LED bank, successor to the fixed 8-LED flowing-light block. It rotates a single lit LED across `WIDTH` outputs at a programmable step rate. Three motion modes are supported (left, right, ping-pong) plus a hold mode. A button start/pause control with synchronised edge detection is included, with optional debounce. It sits directly between the board clock/button pins and the LED pins.

---
 rtl/led_chaser.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/led_chaser.sv
// -----------------------------------------------------------------------------
// led_chaser
//
// Running-light driver for the board LED bank. A single lit LED is moved
// across WIDTH outputs once every TICK_DIV clock cycles. The motion pattern is
// selected by `mode`:
//   2'b00 rotate left  (toward MSB, MSB wraps to bit 0)
//   2'b01 rotate right (bit 0 wraps to MSB)
//   2'b10 ping-pong    (bounces between bit 0 and bit WIDTH-1)
//   2'b11 hold         (LED frozen, step counter keeps running)
//
// A push button toggles between running and paused. The first press after
// reset starts the chaser from bit 0. Only reset returns the block to idle.
//
// Optional feature:
//   LED_CHASER_DEBOUNCE_EN - when defined, the synchronised button level must
//   be stable for DEB_CYCLES consecutive cycles before it is accepted. When
//   undefined, no debounce logic exists and DEB_CYCLES is ignored.
//
// Parameters:
//   WIDTH      number of LEDs (>= 1)
//   TICK_DIV   clk cycles per LED step (>= 2)
//   DEB_CYCLES debounce stability window in clk cycles
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   rst      in   asynchronous active-low reset
//   button   in   asynchronous start/pause request, one press per rising edge
//   mode     in   motion mode, sampled only on step ticks
//   led      out  LED drive, one-hot while active, all-zero when idle
//   running  out  high while the chaser is in the RUN state
// -----------------------------------------------------------------------------
module led_chaser #(
    parameter int WIDTH      = 8,
    parameter int TICK_DIV   = 100_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             running
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    state_t          state;
    dir_t            dir;
    logic [CW-1:0]   cnt;
    logic            tick;

    // -------------------------------------------------------------------------
    // Button synchroniser and edge detection
    // -------------------------------------------------------------------------
    logic sync_meta;
    logic sync;
    logic edge_src;
    logic edge_d;
    logic press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= button;
            sync      <= sync_meta;
        end
    end

`ifdef LED_CHASER_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          deb_level;
    logic [DW-1:0] deb_cnt;

    // The accepted level flips only after the synchronised input has differed
    // from it on DEB_CYCLES consecutive edges; any agreement restarts the
    // window, so short glitches never reach the edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (sync == deb_level) begin
            deb_cnt   <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb_level <= sync;
            deb_cnt   <= '0;
        end else begin
            deb_cnt   <= deb_cnt + 1'b1;
        end
    end

    assign edge_src = deb_level;
`else
    assign edge_src = sync;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_d <= 1'b0;
        end else begin
            edge_d <= edge_src;
        end
    end

    assign press = edge_src & ~edge_d;

    // -------------------------------------------------------------------------
    // Step tick
    // -------------------------------------------------------------------------
    assign tick = (cnt == CW'(TICK_DIV - 1));

    // -------------------------------------------------------------------------
    // Next-position logic
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] step_led;
    dir_t             step_dir;
    logic             led_onehot;

    assign led_onehot = (led != '0) && ((led & (led - WIDTH'(1))) == '0);

    generate
        if (WIDTH == 1) begin : g_single
            always_comb begin
                step_led = led;
                step_dir = dir;
            end
        end else begin : g_multi
            logic [WIDTH-1:0] led_rol;
            logic [WIDTH-1:0] led_ror;
            logic             going_left;

            assign led_rol = {led[WIDTH-2:0], led[WIDTH-1]};
            assign led_ror = {led[0], led[WIDTH-1:1]};

            // A mode change can leave the LED parked on an end bit with dir
            // still pointing outward; bounce off it instead of shifting out.
            assign going_left = ((dir == DIR_LEFT)  && !led[WIDTH-1]) ||
                                ((dir == DIR_RIGHT) &&  led[0]);

            always_comb begin
                step_led = led;
                step_dir = dir;
                case (mode)
                    2'b00: step_led = led_rol;
                    2'b01: step_led = led_ror;
                    2'b10: begin
                        step_led = going_left ? (led << 1) : (led >> 1);
                        // Reverse on the step that lands on an end bit so each
                        // end is lit for exactly one tick period.
                        if (step_led[WIDTH-1]) begin
                            step_dir = DIR_RIGHT;
                        end else if (step_led[0]) begin
                            step_dir = DIR_LEFT;
                        end else begin
                            step_dir = going_left ? DIR_LEFT : DIR_RIGHT;
                        end
                    end
                    default: begin
                        step_led = led;
                        step_dir = dir;
                    end
                endcase
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            led     <= '0;
            running <= 1'b0;
            cnt     <= '0;
            dir     <= DIR_LEFT;
        end else begin
            case (state)
                S_IDLE: begin
                    led <= '0;
                    cnt <= '0;
                    if (press) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        led     <= WIDTH'(1);
                        dir     <= DIR_LEFT;
                    end
                end

                S_RUN: begin
                    // A press on a tick cycle wins: the counter stays at
                    // TICK_DIV-1 so the pending step fires right after resume.
                    if (press) begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end else begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick && led_onehot) begin
                            led <= step_led;
                            dir <= step_dir;
                        end
                    end
                end

                S_PAUSE: begin
                    if (press) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                    led     <= '0;
                    cnt     <= '0;
                    dir     <= DIR_LEFT;
                end
            endcase

            // Corrupted LED pattern while active: snap back to bit 0.
            if (((state == S_RUN) || (state == S_PAUSE)) && !led_onehot) begin
                led <= WIDTH'(1);
                dir <= DIR_LEFT;
            end
        end
    end

endmodule
